// File: rtl/midi_pkg.sv
// Shared MIDI constants, event record and status-byte helpers used by the
// event framer and its FIFO.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF    = 4'h8;
    localparam logic [3:0] NOTE_ON     = 4'h9;
    localparam logic [3:0] POLY_AT     = 4'hA;
    localparam logic [3:0] CTRL_CHANGE = 4'hB;
    localparam logic [3:0] PROG_CHANGE = 4'hC;
    localparam logic [3:0] CHAN_AT     = 4'hD;
    localparam logic [3:0] PITCH_BEND  = 4'hE;

    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] MTC_QF       = 8'hF1;
    localparam logic [7:0] SONG_POS     = 8'hF2;
    localparam logic [7:0] SONG_SEL     = 8'hF3;
    localparam logic [7:0] TUNE_REQ     = 8'hF6;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    localparam int EVENT_W = 22;

    typedef struct packed {
        logic [7:0] command;
        logic [6:0] param_1;
        logic [6:0] param_2;
    } midi_event_t;

    // Data bytes carried by a channel-voice message, keyed on the status high nibble.
    function automatic logic [1:0] data_count(input logic [3:0] status_hi);
        return (status_hi == PROG_CHANGE || status_hi == CHAN_AT) ? 2'd1 : 2'd2;
    endfunction

    // Data bytes to discard after a system-common status byte.
    function automatic logic [1:0] skip_count(input logic [7:0] status);
        logic [1:0] n;
        n = 2'd0;
        if (status == MTC_QF || status == SONG_SEL)
            n = 2'd1;
        else if (status == SONG_POS)
            n = 2'd2;
        return n;
    endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// Show-ahead synchronous FIFO for completed MIDI events; the head entry is
// visible combinationally from register storage as soon as it is written.
module midi_event_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVENT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign do_pop    = pop && !empty;
    // A pop on the same edge frees the slot, so a push at full still lands.
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign head_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/midi_event_framer.sv
// MIDI byte-stream parser: running status, real-time passthrough, SysEx skip,
// channel filter, event FIFO. Define MIDI_FRAMER_VEL0_NOTEOFF_EN to turn 9n kk 00 into 8n kk 00.
module midi_event_framer
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CHANNEL    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       midi_event_valid,
    output logic [7:0] midi_command,
    output logic [6:0] midi_parameter_1,
    output logic [6:0] midi_parameter_2,
    input  logic       midi_event_ack,
    output logic       overflow
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_D1 = 3'd1;
    localparam logic [2:0] ST_WAIT_D2 = 3'd2;
    localparam logic [2:0] ST_SYSEX   = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    logic [2:0]  state_reg,  state_next;
    logic [7:0]  status_reg, status_next;
    logic [6:0]  p1_reg,     p1_next;
    logic [1:0]  skip_reg,   skip_next;
    logic        overflow_reg;

    logic        emit;
    midi_event_t emit_event;
    midi_event_t head_event;
    logic        channel_match;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    always_comb begin
        state_next  = state_reg;
        status_next = status_reg;
        p1_next     = p1_reg;
        skip_next   = skip_reg;
        emit        = 1'b0;
        emit_event  = '{command: status_reg, param_1: p1_reg, param_2: 7'd0};

        if (rx_valid) begin
            if (rx_data >= REALTIME_MIN) begin
                state_next = state_reg;
            end else if (rx_data[7] && rx_data < SYSEX_START) begin
                status_next = rx_data;
                state_next  = ST_WAIT_D1;
            end else if (rx_data == SYSEX_START) begin
                status_next = 8'd0;
                state_next  = ST_SYSEX;
            end else if (rx_data == SYSEX_END) begin
                if (state_reg == ST_SYSEX)
                    state_next = ST_IDLE;
            end else if (rx_data[7]) begin
                status_next = 8'd0;
                skip_next   = skip_count(rx_data);
                state_next  = (skip_count(rx_data) == 2'd0) ? ST_IDLE : ST_SKIP;
            end else begin
                case (state_reg)
                    ST_WAIT_D1: begin
                        p1_next = rx_data[6:0];
                        if (data_count(status_reg[7:4]) == 2'd2) begin
                            state_next = ST_WAIT_D2;
                        end else begin
                            emit               = 1'b1;
                            emit_event.param_1 = rx_data[6:0];
                        end
                    end
                    ST_WAIT_D2: begin
                        emit               = 1'b1;
                        emit_event.param_2 = rx_data[6:0];
                        state_next         = ST_WAIT_D1;
                    end
                    ST_SKIP: begin
                        skip_next = skip_reg - 2'd1;
                        if (skip_reg <= 2'd1)
                            state_next = ST_IDLE;
                    end
                    default: state_next = state_reg;
                endcase
            end
        end

`ifdef MIDI_FRAMER_VEL0_NOTEOFF_EN
        if (emit_event.command[7:4] == NOTE_ON && emit_event.param_2 == 7'd0)
            emit_event.command = {NOTE_OFF, emit_event.command[3:0]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            status_reg   <= 8'd0;
            p1_reg       <= 7'd0;
            skip_reg     <= 2'd0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            status_reg <= status_next;
            p1_reg     <= p1_next;
            skip_reg   <= skip_next;
            if (fifo_drop)
                overflow_reg <= 1'b1;
        end
    end

    // Filtered messages still advance the parser; only the push is suppressed.
    assign channel_match = (CHANNEL == 16) || (status_reg[3:0] == 4'(CHANNEL));

    midi_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (emit && channel_match),
        .push_data (emit_event),
        .pop       (midi_event_ack),
        .head_data (head_event),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    // Storage is not reset, so fields are forced to zero whenever the FIFO is empty.
    assign midi_event_valid = !fifo_empty;
    assign midi_command     = fifo_empty ? 8'd0 : head_event.command;
    assign midi_parameter_1 = fifo_empty ? 7'd0 : head_event.param_1;
    assign midi_parameter_2 = fifo_empty ? 7'd0 : head_event.param_2;
    assign overflow         = overflow_reg;

endmodule

// File: doc/midi_event_framer.md
# midi_event_framer

- Sits between the UART receiver (`simpleuart` byte output) and the MIDI note processor.
- Parses the raw MIDI byte stream into complete channel-voice events:
  - running status
  - interleaved real-time bytes
  - SysEx skipping
  - channel filtering
- Buffers completed events in a small FIFO.
- Presents them on the valid/ack event interface consumed by the voice allocator.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `CHANNEL`, 16: MIDI channel accepted (0–15); 16 = omni (all channels).

Ports:
- `clk` in 1: system clock (16 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `midi_event_valid` out 1: FIFO head holds an event.
- `midi_command` out 8: status byte of head event.
- `midi_parameter_1` out 7: first data byte of head event.
- `midi_parameter_2` out 7: second data byte of head event; 0 for one-data-byte messages.
- `midi_event_ack` in 1: consumer acknowledge.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.

## Operation
Byte classes:
- 0xF8–0xFF (real-time): ignored entirely; parser state is untouched.
- 0x80–0xEF (channel status):
  - Latch as running status and clear any partial message.
  - Expected data count: 2 for 8x/9x/Ax/Bx/Ex, 1 for Cx/Dx.
- 0xF0: clear running status; enter SYSEX.
- 0xF1–0xF6: clear running status.
  - F1/F3 skip 1 data byte; F2 skips 2; F6 skips none.
  - Nothing is emitted.
- 0xF7: leaves SYSEX to IDLE; otherwise ignored.
- 0x00–0x7F (data): handled per state.

Parser states:
- IDLE: no running status. Data bytes are dropped.
- WAIT_D1: store the byte to `p1`.
  - 2-byte message → WAIT_D2.
  - 1-byte message → emit {status, p1, 0}, stay WAIT_D1.
- WAIT_D2: store the byte to `p2`, emit {status, p1, p2}, → WAIT_D1 (running status reuse).
- SYSEX: data bytes dropped. F7 → IDLE. Channel status → WAIT_D1 with new status.
- SKIP: counts down the skip bytes, then → IDLE.

Emit and FIFO rules:
- Emit pushes into the FIFO only if `CHANNEL`==16 or status[3:0]==`CHANNEL`.
- Filtered messages are still parsed, and running status is still tracked.
- Full FIFO on push without a same-cycle pop: event dropped, `overflow` set until reset.
- Pop: every cycle with `midi_event_ack`=1 and `midi_event_valid`=1 pops exactly one entry. Ack while empty is ignored.
- The consumer raises ack for one cycle per event and drops it the next cycle. Each ack pulse consumes exactly one event.
- Simultaneous push and pop: both occur. Allowed at full; occupancy unchanged.

## Timing
- Reset values: all outputs 0, FIFO empty, parser IDLE, running status cleared. Reset mid-message discards the partial message and all buffered events.
- Latency: final byte sampled at edge N. With the FIFO empty, `midi_event_valid` and the head fields are high/valid from edge N.
- Outputs come from registered FIFO head storage. Fields stay stable while valid=1 and not popped.
- After a popping edge, the next entry (if any) is presented immediately; otherwise valid=0.
- Throughput: one byte per `rx_valid` cycle. `rx_valid` may be asserted on consecutive cycles.

## Configuration
- `MIDI_FRAMER_VEL0_NOTEOFF_EN` defined: a note-on with velocity 0 (9n kk 00) is emitted as 8n kk 00.
- Undefined: emitted unchanged as 9n kk 00.
- The conversion is applied before channel filtering and the FIFO push.

## Structure
- Shared package `midi_pkg`:
  - status-class constants (NOTE_OFF=8, NOTE_ON=9, …, SYSEX_START=F0, SYSEX_END=F7)
  - real-time threshold F8
  - event width 22
  - function returning the data-byte count for a status byte
- Sub-module `midi_event_fifo`:
  - synchronous FIFO, width 22, depth `FIFO_DEPTH`
  - show-ahead head, push/pop/full/empty
- Parser FSM stays in the top module.

## Test plan
- 90 3C 64, then 3E 50 (running status) → events {90,3C,64}, {90,3E,50}; ack each → valid drops after the second pop.
- 90 3C F8 64 (clock byte mid-message) → single event {90,3C,64}; F0 01 02 F7 3C 40 → no events.
- C5 07 with `CHANNEL`=5 → {C5,07,00}; 91 3C 64 with `CHANNEL`=5 → nothing; with `CHANNEL`=16 → emitted.
- `FIFO_DEPTH`=4, six note-ons with no ack → four events held, `overflow`=1. Push coinciding with ack at full → accepted, count stays 4.
- 90 3C 00 → {80,3C,00} with macro, {90,3C,00} without.
- `rst_n` low after 90 3C → outputs 0. After release, bytes 64 → no event (no running status).
